// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding,
// opcode values (Instr[6:2]), control-word field positions and trap causes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Major opcodes as seen on Instr[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'd0;
    localparam logic [4:0] OPC_OPIMM  = 5'd4;
    localparam logic [4:0] OPC_AUIPC  = 5'd5;
    localparam logic [4:0] OPC_STORE  = 5'd8;
    localparam logic [4:0] OPC_OP     = 5'd12;
    localparam logic [4:0] OPC_LUI    = 5'd13;
    localparam logic [4:0] OPC_BRANCH = 5'd24;
    localparam logic [4:0] OPC_JALR   = 5'd25;
    localparam logic [4:0] OPC_JAL    = 5'd27;

    // Decoder control word bit positions
    localparam int CW_PC_SEL      = 14;
    localparam int CW_IMM_SEL_HI  = 13;
    localparam int CW_IMM_SEL_LO  = 11;
    localparam int CW_REG_WEN     = 10;
    localparam int CW_BR_UN       = 9;
    localparam int CW_B_SEL       = 8;
    localparam int CW_A_SEL       = 7;
    localparam int CW_ALU_SEL_HI  = 6;
    localparam int CW_ALU_SEL_LO  = 3;
    localparam int CW_MEM_RW      = 2;
    localparam int CW_WB_SEL_HI   = 1;
    localparam int CW_WB_SEL_LO   = 0;

    // Trap cause codes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    // True for every opcode this core executes; anything else traps in DECODE
    function automatic logic opcode_legal(input logic [4:0] opc);
        logic legal;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Loads and stores are the only instructions that visit MEM
    function automatic logic opcode_is_mem(input logic [4:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive un-acknowledged request cycles. 'expired' flags the
// cycle in which the count would reach MAX_WAIT, so the FSM can leave on
// that same edge; an acknowledge in that cycle drops 'en' and wins.
module wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] count_reg;

    // Wait-cycle counter: clear has priority over counting
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = en && (count_reg == LAST_COUNT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory wait handling, timeout and illegal-opcode traps, and a retired
// instruction counter. Request outputs depend on state only; the load
// strobes that must coincide with an acknowledge are qualified by ready.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  opcode_i,
    input  logic [14:0] ctrl_word_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic        reg_we_o,
    output logic        trap_o,
    output logic [1:0]  cause_o,
    output logic [31:0] instret_o
);

    state_t      state_reg;
    logic        trap_reg;
    logic [1:0]  cause_reg;
    logic [31:0] instret_reg;

    logic in_fetch;
    logic in_mem;
    logic in_wb;
    logic is_store;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;
    logic ctrl_unused;

    assign in_fetch = (state_reg == ST_FETCH);
    assign in_mem   = (state_reg == ST_MEM);
    assign in_wb    = (state_reg == ST_WB);
    assign is_store = (opcode_i == OPC_STORE);

    // Count while a request is outstanding; clear once it is acknowledged or
    // outside the request states, so the count is zero on entering FETCH/MEM.
    assign timer_en  = (in_fetch && !imem_ready_i) || (in_mem && !dmem_ready_i);
    assign timer_clr = !(in_fetch || in_mem)
                     || (in_fetch && imem_ready_i)
                     || (in_mem && dmem_ready_i);

    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Main sequencer: state, trap flag/cause and retired-instruction count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            trap_reg    <= 1'b0;
            cause_reg   <= CAUSE_NONE;
            instret_reg <= '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (imem_ready_i) begin
                        state_reg <= ST_DECODE;
                    end else if (timer_expired) begin
                        state_reg <= ST_TRAP;
                        trap_reg  <= 1'b1;
                        cause_reg <= CAUSE_IMEM_TO;
                    end
                end
                ST_DECODE: begin
                    if (opcode_legal(opcode_i)) begin
                        state_reg <= ST_EXEC;
                    end else begin
                        state_reg <= ST_TRAP;
                        trap_reg  <= 1'b1;
                        cause_reg <= CAUSE_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    state_reg <= opcode_is_mem(opcode_i) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ready_i) begin
                        if (is_store) begin
                            state_reg   <= ST_FETCH;
                            instret_reg <= instret_reg + 32'd1;
                        end else begin
                            state_reg <= ST_WB;
                        end
                    end else if (timer_expired) begin
                        state_reg <= ST_TRAP;
                        trap_reg  <= 1'b1;
                        cause_reg <= CAUSE_DMEM_TO;
                    end
                end
                ST_WB: begin
                    state_reg   <= ST_FETCH;
                    instret_reg <= instret_reg + 32'd1;
                end
                ST_TRAP: begin
                    state_reg <= ST_TRAP;
                end
                default: begin
                    state_reg <= ST_TRAP;
                end
            endcase
        end
    end

    // Output decode; everything is forced low while reset is held
    always_comb begin
        imem_req_o = 1'b0;
        ir_we_o    = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        pc_we_o    = 1'b0;
        pc_sel_o   = 1'b0;
        reg_we_o   = 1'b0;
        if (!rst) begin
            imem_req_o = in_fetch;
            ir_we_o    = in_fetch && imem_ready_i;
            dmem_req_o = in_mem;
            dmem_we_o  = in_mem && ctrl_word_i[CW_MEM_RW];
            pc_we_o    = in_wb || (in_mem && dmem_ready_i && is_store);
            pc_sel_o   = in_wb && ctrl_word_i[CW_PC_SEL];
            reg_we_o   = in_wb && ctrl_word_i[CW_REG_WEN];
        end
    end

    assign trap_o    = trap_reg;
    assign cause_o   = cause_reg;
    assign instret_o = instret_reg;

    // Datapath-only control fields pass through this block untouched
    assign ctrl_unused = ^{ctrl_word_i[CW_IMM_SEL_HI:CW_IMM_SEL_LO],
                           ctrl_word_i[CW_BR_UN],
                           ctrl_word_i[CW_B_SEL],
                           ctrl_word_i[CW_A_SEL],
                           ctrl_word_i[CW_ALU_SEL_HI:CW_ALU_SEL_LO],
                           ctrl_word_i[CW_WB_SEL_HI:CW_WB_SEL_LO]};

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: maximum number of consecutive un-acknowledged memory-request cycles before a timeout trap.
REQ-002 SHALL have port clk  in  1  system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port opcode_i  in  5  Instr[6:2] of the latched instruction register.
REQ-005 SHALL have port ctrl_word_i  in  15  decoder control word with these fields:
  - [14] pc_sel
  - [13:11] imm_sel
  - [10] reg_wen
  - [9] br_un
  - [8] b_sel
  - [7] a_sel
  - [6:3] alu_sel
  - [2] mem_rw
  - [1:0] wb_sel
REQ-006 SHALL have port imem_ready_i  in  1  instruction memory acknowledge.
REQ-007 SHALL have port dmem_ready_i  in  1  data memory acknowledge.
REQ-008 SHALL have port imem_req_o  out  1  instruction fetch request.
REQ-009 SHALL have port dmem_req_o  out  1  data access request.
REQ-010 SHALL have port dmem_we_o  out  1  data write enable; qualified by dmem_req_o.
REQ-011 SHALL have port ir_we_o  out  1  instruction register load strobe.
REQ-012 SHALL have port pc_we_o  out  1  PC update strobe.
REQ-013 SHALL have port pc_sel_o  out  1  PC source: 0 = PC+4, 1 = ALU.
REQ-014 SHALL have port reg_we_o  out  1  register file write strobe.
REQ-015 SHALL have port trap_o  out  1  sticky trap flag.
REQ-016 SHALL have port cause_o  out  2  trap cause:
  - 01 illegal opcode
  - 10 instruction-memory timeout
  - 11 data-memory timeout
REQ-017 SHALL have port instret_o  out  32  retired-instruction count.

Function
REQ-018 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-019 FETCH SHALL hold imem_req_o=1 until imem_ready_i=1, then pulse ir_we_o=1 for that same cycle and go to DECODE.
REQ-020 DECODE SHALL last exactly 1 cycle and go to EXEC if opcode_i is in {0,4,5,8,12,13,24,25,27}, otherwise to TRAP with cause 01.
REQ-021 EXEC SHALL last exactly 1 cycle and go to MEM if opcode_i is 0 or 8, otherwise to WB.
REQ-022 MEM SHALL hold dmem_req_o=1 and dmem_we_o=ctrl_word_i[2] until dmem_ready_i=1; on that cycle:
  - load (opcode 0): go to WB.
  - store (opcode 8): pulse pc_we_o=1, increment instret_o, go to FETCH.
REQ-023 WB SHALL last 1 cycle and:
  - drive reg_we_o=ctrl_word_i[10], pc_we_o=1 and pc_sel_o=ctrl_word_i[14];
  - increment instret_o;
  - go to FETCH.
REQ-024 pc_sel_o, reg_we_o, ir_we_o and pc_we_o SHALL be 0 in every state and cycle not listed above.
REQ-025 All outputs SHALL be registered-state decodes only, with no combinational path from a ready input to a request output.
REQ-026 Latency per instruction with zero-wait memory SHALL be:
  - 4 cycles for ALU, branch, jump and U-type instructions;
  - 5 cycles for loads;
  - 4 cycles for stores.
REQ-027 The wait counter SHALL clear on entering FETCH or MEM and increment on each cycle the request is high with ready low.
REQ-028 When the wait counter reaches MAX_WAIT, the block SHALL go to TRAP with cause 10 from FETCH or cause 11 from MEM.
REQ-029 If ready is asserted in the same cycle the counter reaches MAX_WAIT, ready SHALL win and no trap SHALL be taken.
REQ-030 TRAP SHALL be absorbing until rst:
  - trap_o=1 and cause_o held;
  - all request and strobe outputs 0;
  - instret_o frozen.
REQ-031 instret_o SHALL wrap from 0xFFFFFFFF to 0 without any flag.
REQ-032 Ready inputs arriving in a state that does not hold the matching request SHALL be ignored.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL set the state to FETCH, instret_o to 0, the wait counter to 0, trap_o to 0 and cause_o to 00.
REQ-034 While in reset, the block SHALL hold all strobe and request outputs at 0.
REQ-035 Reset SHALL take effect from any state, including a pending memory request, and that request SHALL be abandoned.
REQ-036 In the first cycle after rst falls, imem_req_o SHALL be 1.

Structure
REQ-037 Package rv_ctrl_pkg SHALL hold the state enum, the opcode constants (LOAD=0, OPIMM=4, AUIPC=5, STORE=8, OP=12, LUI=13, BRANCH=24, JALR=25, JAL=27), the ctrl_word bit-index constants and the cause codes.
REQ-038 The timeout counter SHALL be a sub-module named wait_timer, with ports clk, rst, clr, en, expired and parameter MAX_WAIT.

Verification
REQ-039 Zero-wait memory, ADD then LW then SW -> instret_o=3 after 13 cycles; reg_we_o pulses exactly twice; dmem_we_o=1 only during the SW MEM cycle.
REQ-040 imem_ready_i delayed 3 cycles -> imem_req_o held 4 cycles, then exactly one ir_we_o pulse.
REQ-041 opcode_i=31 -> trap_o=1 and cause_o=01 from the cycle after DECODE; instret_o unchanged for 20 or more further cycles.
REQ-042 MAX_WAIT=4, dmem_ready_i stuck at 0 on a load -> TRAP with cause 11 after 4 wait cycles; with ready on the 4th cycle -> no trap.
REQ-043 Branch with ctrl_word_i[14]=1 -> pc_sel_o=1 and pc_we_o=1 in WB; with ctrl_word_i[14]=0 -> pc_sel_o=0.
REQ-044 rst asserted mid-MEM with a pending request -> next cycle FETCH, dmem_req_o=0, instret_o=0, trap_o=0.
